init_io_ctrl: RTL

- DUT-side responder for the host init/IO port driven by the synchronous testbench.
- Accepts instruction-memory writes into a ping-pong instruction buffer and data-memory reads/writes, decoding them into per-bank strobes.
- Sequences execution start and completion with the core, and exposes the core's current instruction read address back to the host.
- Sits between the top-level host pins and the instruction memory, data-memory banks and core control.

---
 rtl/init_io_ctrl_pkg.sv | 27 ++
 rtl/init_data_bank_if.sv | 86 ++++++++
 rtl/init_io_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/init_io_ctrl_pkg.sv
// Shared widths, types and FSM state constants for the host init/IO responder.
package init_io_ctrl_pkg;

  localparam int INSTR_L          = 32;
  localparam int INSTR_MEM_ADDR_L = 10;
  localparam int WORD_L           = 32;
  localparam int N_BANKS          = 8;
  localparam int DATA_MEM_ADDR_L  = 9;
  localparam int BANK_IDX_L       = $clog2(N_BANKS);
  localparam int DATA_ADDR_L      = BANK_IDX_L + DATA_MEM_ADDR_L;

  typedef logic [INSTR_MEM_ADDR_L-1:0] instr_addr_t;
  typedef logic [WORD_L-1:0]           word_t;
  typedef logic [BANK_IDX_L-1:0]       bank_idx_t;
  typedef logic [DATA_MEM_ADDR_L-1:0]  bank_addr_t;
  typedef logic [N_BANKS-1:0]          bank_mask_t;
  typedef logic [1:0]                  state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic bank_mask_t bank_onehot(input bank_idx_t idx);
    return bank_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/init_data_bank_if.sv
// Data-memory access decode: one-hot bank strobes and the two-stage read-return pipeline.
module init_data_bank_if
  import init_io_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        acc_en,
  input  logic                        data_we,
  input  logic                        data_re,
  input  logic [DATA_ADDR_L-1:0]      data_addr,
  input  word_t                       data_in,
  input  logic [N_BANKS*WORD_L-1:0]   bank_rdata,
  output bank_mask_t                  bank_we,
  output bank_mask_t                  bank_re,
  output bank_addr_t                  bank_addr,
  output word_t                       bank_wdata,
  output word_t                       data_out,
  output logic                        acc_err
);

  bank_mask_t bank_we_q, bank_we_d, bank_re_q, bank_re_d;
  bank_addr_t bank_addr_q, bank_addr_d;
  word_t      bank_wdata_q, bank_wdata_d, data_out_q, data_out_d;
  bank_idx_t  rd_bank1_q, rd_bank1_d, rd_bank2_q, rd_bank2_d;
  logic       rd_v2_q, rd_v2_d;
  bank_idx_t  req_bank;

  assign req_bank = data_addr[DATA_ADDR_L-1 -: BANK_IDX_L];

  always_comb begin
    bank_we_d    = '0;
    bank_re_d    = '0;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    rd_bank1_d   = rd_bank1_q;
    rd_v2_d      = |bank_re_q;
    rd_bank2_d   = rd_bank1_q;
    data_out_d   = data_out_q;
    acc_err      = 1'b0;
    // Bank memories register their read at the edge after bank_re; capture one edge later.
    if (rd_v2_q) data_out_d = bank_rdata[int'(rd_bank2_q)*WORD_L +: WORD_L];
    if (data_we || data_re) begin
      if (!acc_en) begin
        acc_err = 1'b1;
      end else if (data_we) begin
        bank_we_d    = bank_onehot(req_bank);
        bank_addr_d  = data_addr[DATA_MEM_ADDR_L-1:0];
        bank_wdata_d = data_in;
        acc_err      = data_re;
      end else begin
        bank_re_d   = bank_onehot(req_bank);
        bank_addr_d = data_addr[DATA_MEM_ADDR_L-1:0];
        rd_bank1_d  = req_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_we_q    <= '0;
      bank_re_q    <= '0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      rd_bank1_q   <= '0;
      rd_bank2_q   <= '0;
      rd_v2_q      <= 1'b0;
      data_out_q   <= '0;
    end else begin
      bank_we_q    <= bank_we_d;
      bank_re_q    <= bank_re_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
      rd_bank1_q   <= rd_bank1_d;
      rd_bank2_q   <= rd_bank2_d;
      rd_v2_q      <= rd_v2_d;
      data_out_q   <= data_out_d;
    end
  end

  assign bank_we    = bank_we_q;
  assign bank_re    = bank_re_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;
  assign data_out   = data_out_q;

endmodule

// File: rtl/init_io_ctrl.sv
// Host init/IO responder: ping-pong instruction writes, banked data access, run sequencing.
// Optional exec_cycles performance counter when INIT_IO_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a rising edge of enable_execution
// RUN   | core executing; data access and writes to the executing half are rejected
// DONE  | core finished; waits for enable_execution to drop
module init_io_ctrl
  import init_io_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_execution,
  input  logic [INSTR_L-1:0]            init_instr,
  input  logic [INSTR_MEM_ADDR_L-1:0]   init_instr_addr,
  input  logic                          init_instr_we,
  input  logic                          io_ping_wr,
  output logic [INSTR_MEM_ADDR_L-1:0]   current_instr_rd_addr,
  input  logic [WORD_L-1:0]             init_data_in,
  output logic [WORD_L-1:0]             init_data_out,
  input  logic [DATA_ADDR_L-1:0]        init_data_addr,
  input  logic                          init_data_we,
  input  logic                          init_data_re,
  output logic                          instr_mem_we,
  output logic [INSTR_MEM_ADDR_L:0]     instr_mem_addr,
  output logic [INSTR_L-1:0]            instr_mem_wdata,
  output logic                          exec_ping,
  output logic                          exec_start,
  input  logic                          exec_done,
  input  logic [INSTR_MEM_ADDR_L-1:0]   exec_instr_rd_addr,
  output logic [N_BANKS-1:0]            bank_we,
  output logic [N_BANKS-1:0]            bank_re,
  output logic [DATA_MEM_ADDR_L-1:0]    bank_addr,
  output logic [WORD_L-1:0]             bank_wdata,
  input  logic [N_BANKS*WORD_L-1:0]     bank_rdata,
`ifdef INIT_IO_PERF_CNT_EN
  output logic [31:0]                   exec_cycles,
`endif
  output logic                          busy,
  output logic                          io_err
);

  state_t                    state_q, state_d;
  logic                      en_prev_q, en_prev_d;
  logic                      exec_start_q, exec_start_d;
  logic                      exec_ping_q, exec_ping_d;
  logic                      busy_q, busy_d;
  instr_addr_t               pc_q, pc_d;
  logic                      instr_we_q, instr_we_d;
  logic [INSTR_MEM_ADDR_L:0] instr_addr_q, instr_addr_d;
  logic [INSTR_L-1:0]        instr_wdata_q, instr_wdata_d;
  logic                      io_err_q, io_err_d;
  logic                      instr_drop;
  logic                      data_err;
  logic                      running;

  assign running = (state_q == ST_RUN);

  always_comb begin
    state_d      = state_q;
    exec_start_d = 1'b0;
    exec_ping_d  = exec_ping_q;
    en_prev_d    = enable_execution;
    case (state_q)
      ST_IDLE: begin
        if (enable_execution && !en_prev_q) begin
          state_d      = ST_RUN;
          exec_start_d = 1'b1;
          exec_ping_d  = ~io_ping_wr;
        end
      end
      ST_RUN:  if (exec_done) state_d = ST_DONE;
      ST_DONE: if (!enable_execution) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    pc_d   = running ? exec_instr_rd_addr : pc_q;

    // The host may refill only the half the core is not executing from.
    instr_drop    = init_instr_we && running && (io_ping_wr == exec_ping_q);
    instr_we_d    = init_instr_we && !instr_drop;
    instr_addr_d  = instr_addr_q;
    instr_wdata_d = instr_wdata_q;
    if (instr_we_d) begin
      instr_addr_d  = {io_ping_wr, init_instr_addr};
      instr_wdata_d = init_instr;
    end
    io_err_d = io_err_q | instr_drop | data_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      en_prev_q     <= 1'b0;
      exec_start_q  <= 1'b0;
      exec_ping_q   <= 1'b0;
      busy_q        <= 1'b0;
      pc_q          <= '0;
      instr_we_q    <= 1'b0;
      instr_addr_q  <= '0;
      instr_wdata_q <= '0;
      io_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_prev_q     <= en_prev_d;
      exec_start_q  <= exec_start_d;
      exec_ping_q   <= exec_ping_d;
      busy_q        <= busy_d;
      pc_q          <= pc_d;
      instr_we_q    <= instr_we_d;
      instr_addr_q  <= instr_addr_d;
      instr_wdata_q <= instr_wdata_d;
      io_err_q      <= io_err_d;
    end
  end

`ifdef INIT_IO_PERF_CNT_EN
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (exec_start_d) cycles_d = '0;
    else if (running && (cycles_q != 32'hFFFF_FFFF)) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycles_q <= '0;
    else      cycles_q <= cycles_d;
  end

  assign exec_cycles = cycles_q;
`endif

  init_data_bank_if u_data_bank_if (
    .clk        (clk),
    .rst        (rst),
    .acc_en     (!running),
    .data_we    (init_data_we),
    .data_re    (init_data_re),
    .data_addr  (init_data_addr),
    .data_in    (init_data_in),
    .bank_rdata (bank_rdata),
    .bank_we    (bank_we),
    .bank_re    (bank_re),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .data_out   (init_data_out),
    .acc_err    (data_err)
  );

  assign current_instr_rd_addr = pc_q;
  assign instr_mem_we          = instr_we_q;
  assign instr_mem_addr        = instr_addr_q;
  assign instr_mem_wdata       = instr_wdata_q;
  assign exec_ping             = exec_ping_q;
  assign exec_start            = exec_start_q;
  assign busy                  = busy_q;
  assign io_err                = io_err_q;

endmodule
